// File: rtl/ffapuf_pkg.sv
// ffapuf_pkg
// Shared types and default constants for the feed-forward arbiter PUF
// evaluation controller and its helpers.
//   state_t       : controller sequencing states
//   *_DEF         : default parameter values for one PUF level
//   max2          : elaboration-time helper used for counter sizing
package ffapuf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RACE,
        SAMPLE,
        DONE
    } state_t;

    localparam int CW_DEF            = 32;
    localparam int CLR_CYCLES_DEF    = 4;
    localparam int SETTLE_CYCLES_DEF = 16;
    localparam int NUM_EVAL_DEF      = 15;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/puf_sync2.sv
// puf_sync2
// Two-flop synchroniser for a raw PUF response that is asynchronous to clk.
// Ports:
//   clk : system clock
//   clr : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronised output (two clk edges of latency)
module puf_sync2 (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    // The first flop may go metastable; only the second flop is consumed.
    always_ff @(posedge clk) begin
        if (clr) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ffapuf_eval_ctrl.sv
// ffapuf_eval_ctrl
// Sequencer for one feed-forward arbiter PUF level. Takes a challenge over a
// valid/ready handshake, drives it onto the PUF, runs NUM_EVAL
// clear/race/sample evaluations, majority-votes the sampled bits and hands
// back the voted bit plus the ones-count over a valid/ready handshake.
// Ports:
//   clk, clr               : clock, synchronous active-high reset
//   chal_valid/ready, chal : challenge input handshake
//   resp_valid/ready       : response output handshake
//   resp, resp_ones        : voted bit and number of evaluations that read 1
//   busy                   : high while evaluations are running
//   puf_c, puf_clr         : challenge bus and clear to the PUF level
//   puf_r                  : raw PUF response (asynchronous to clk)
module ffapuf_eval_ctrl
    import ffapuf_pkg::*;
#(
    parameter  int CW            = CW_DEF,
    parameter  int CLR_CYCLES    = CLR_CYCLES_DEF,
    parameter  int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter  int NUM_EVAL      = NUM_EVAL_DEF,
    localparam int OW            = $clog2(NUM_EVAL + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          chal_valid,
    output logic          chal_ready,
    input  logic [CW-1:0] chal,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp,
    output logic [OW-1:0] resp_ones,
    output logic          busy,
    output logic [CW-1:0] puf_c,
    output logic          puf_clr,
    input  logic          puf_r
);

    // Stop the build on parameter sets the sequencing cannot support: an even
    // vote count has no majority, and a short race would let the synchroniser
    // deliver a bit captured while the arbiters were still cleared.
    if ((NUM_EVAL % 2) == 0 || NUM_EVAL < 1 || SETTLE_CYCLES < 3 || CLR_CYCLES < 1) begin : g_bad_params
        $fatal(1, "ffapuf_eval_ctrl: illegal NUM_EVAL/SETTLE_CYCLES/CLR_CYCLES");
    end

    localparam int TMAX = max2(CLR_CYCLES, SETTLE_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] CLR_LAST    = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [OW-1:0] EVAL_LAST   = OW'(NUM_EVAL - 1);
    localparam logic [OW-1:0] HALF        = OW'(NUM_EVAL / 2);

    state_t        state;
    logic [TW-1:0] timer;
    logic [OW-1:0] eval_cnt;
    logic [OW-1:0] ones_cnt;
    logic [OW-1:0] ones_next;
    logic          sync_r;

    puf_sync2 u_sync (
        .clk (clk),
        .clr (clr),
        .d   (puf_r),
        .q   (sync_r)
    );

    // Running vote including the bit being sampled this cycle; used so the
    // final evaluation can be folded straight into the registered response.
    assign ones_next = ones_cnt + OW'(sync_r);

    // Single sequencing process. All handshake and PUF-facing outputs are
    // registered here alongside the state so they change on the same edge as
    // the state they belong to. Reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            puf_c      <= '0;
            puf_clr    <= 1'b1;
            chal_ready <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp       <= 1'b0;
            resp_ones  <= '0;
            timer      <= '0;
            eval_cnt   <= '0;
            ones_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (chal_valid && chal_ready) begin
                        puf_c      <= chal;
                        ones_cnt   <= '0;
                        eval_cnt   <= '0;
                        timer      <= '0;
                        chal_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (timer == CLR_LAST) begin
                        timer   <= '0;
                        puf_clr <= 1'b0;
                        state   <= RACE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RACE: begin
                    if (timer == SETTLE_LAST) begin
                        timer <= '0;
                        state <= SAMPLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SAMPLE: begin
                    ones_cnt <= ones_next;
                    eval_cnt <= eval_cnt + 1'b1;
                    puf_clr  <= 1'b1;
                    if (eval_cnt == EVAL_LAST) begin
                        busy       <= 1'b0;
                        resp_valid <= 1'b1;
                        resp       <= (ones_next > HALF);
                        resp_ones  <= ones_next;
                        state      <= DONE;
                    end else begin
                        state <= CLEAR;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        chal_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
